// File: rtl/jtframe_romrq64_slot.sv
// Read slot for one bank of the 64-bit-burst SDRAM controller: 2-line tag-compared cache.
// Hit latency 1 clk; a miss issues one burst and holds until the fill completes (never aborted).
module jtframe_romrq64_slot #(
  parameter int AW  = 22,
  parameter int DW  = 16,
  parameter int LEN = 64,
  localparam int SAW = AW + ((DW == 32) ? 1 : 0)
) (
  input  logic           rst,
  input  logic           clk,
  input  logic           clr,
  input  logic           cs,
  input  logic [AW-1:0]  addr,
  output logic [DW-1:0]  dout,
  output logic           data_ok,
  output logic [SAW-1:0] sdram_addr,
  output logic           sdram_rd,
  input  logic           sdram_ack,
  input  logic           sdram_dst,
  input  logic           sdram_dok,
  input  logic           sdram_rdy,
  input  logic [15:0]    sdram_din
);

  localparam int WPL  = LEN / 16;
  localparam int OFFW = $clog2(WPL);
  localparam int TW   = SAW - OFFW;
  localparam int SH   = (DW == 32) ? 1 : 0;
  localparam logic [OFFW-1:0] CNT_LAST = OFFW'(WPL - 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, FILL} st_t;

  st_t              st_q;
  logic [1:0]       valid_q;
  logic [TW-1:0]    tag_q  [2];
  logic [LEN-1:0]   line_q [2];
  logic             lru_q, victim_q, clr_pend_q;
  logic [OFFW-1:0]  cnt_q;
  logic [SAW-1:0]   sdram_addr_q;
  logic             sdram_rd_q;
  logic [DW-1:0]    dout_q;
  logic             data_ok_q;

  logic [SAW-1:0]   waddr;
  logic [TW-1:0]    req_tag;
  logic [OFFW-1:0]  widx;
  logic [OFFW+3:0]  boff;
  logic [1:0]       match;
  logic             hit, hit_line, victim_d;
  logic [DW-1:0]    rd_dat;

  // Client address converted to a 16-bit word address, then split into burst tag and word offset
  assign waddr    = SAW'(addr) << SH;
  assign req_tag  = waddr[SAW-1:OFFW];
  assign widx     = waddr[OFFW-1:0];
  assign boff     = {widx, 4'd0};
  assign match[0] = valid_q[0] && (tag_q[0] == req_tag);
  assign match[1] = valid_q[1] && (tag_q[1] == req_tag);
  assign hit      = cs && (|match);
  assign hit_line = ~match[0];
  assign rd_dat   = line_q[hit_line][boff +: DW];
  assign victim_d = !valid_q[0] ? 1'b0 : (!valid_q[1] ? 1'b1 : lru_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q         <= IDLE;
      valid_q      <= '0;
      lru_q        <= 1'b0;
      victim_q     <= 1'b0;
      clr_pend_q   <= 1'b0;
      cnt_q        <= '0;
      sdram_addr_q <= '0;
      sdram_rd_q   <= 1'b0;
      dout_q       <= '0;
      data_ok_q    <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        tag_q[i]  <= '0;
        line_q[i] <= '0;
      end
    end else begin
      data_ok_q <= hit && !clr;
      if (hit) begin
        dout_q <= rd_dat;
        lru_q  <= ~hit_line;
      end
      if (clr) valid_q <= '0;
      // A clr seen while a burst is in flight must keep that line from being installed
      if (clr && st_q != IDLE) clr_pend_q <= 1'b1;
      case (st_q)
        IDLE: if (cs && !hit) begin
          st_q              <= REQ;
          sdram_addr_q      <= {req_tag, {OFFW{1'b0}}};
          victim_q          <= victim_d;
          valid_q[victim_d] <= 1'b0;
          sdram_rd_q        <= 1'b1;
          clr_pend_q        <= 1'b0;
        end
        REQ: if (sdram_ack) begin
          sdram_rd_q <= 1'b0;
          cnt_q      <= '0;
          st_q       <= sdram_dst ? FILL : WAIT;
        end
        WAIT: if (sdram_dst) begin
          cnt_q <= '0;
          st_q  <= FILL;
        end
        FILL: if (sdram_dok) begin
          line_q[victim_q][{cnt_q, 4'd0} +: 16] <= sdram_din;
          cnt_q <= cnt_q + 1'b1;
          if (sdram_rdy) begin
            if (!clr_pend_q && !clr) valid_q[victim_q] <= 1'b1;
            tag_q[victim_q] <= sdram_addr_q[SAW-1:OFFW];
            lru_q           <= ~victim_q;
            st_q            <= IDLE;
          end
        end
        default: st_q <= IDLE;
      endcase
    end
  end

  // The last word of a burst must carry rdy; anything more is controller misbehaviour
  a_no_overrun: assert property (@(posedge clk) disable iff (rst)
    (st_q == FILL && sdram_dok && cnt_q == CNT_LAST) |-> sdram_rdy);

  assign dout       = dout_q;
  assign data_ok    = data_ok_q;
  assign sdram_addr = sdram_addr_q;
  assign sdram_rd   = sdram_rd_q;

endmodule

// File: tb/tb_jtframe_romrq64_slot.sv
// Directed bench: a 16-bit and a 32-bit slot share one modelled bank controller.
module tb_jtframe_romrq64_slot;

  logic        clk = 1'b0, rst = 1'b1, clr = 1'b0;
  logic        cs = 1'b0, b_cs = 1'b0;
  logic [21:0] addr = '0, b_addr = '0;
  logic        ack = 1'b0, dst = 1'b0, dok = 1'b0, rdy = 1'b0;
  logic [15:0] din = '0;

  logic [15:0] dout;
  logic        data_ok, srd;
  logic [21:0] saddr;
  logic [31:0] b_dout;
  logic        b_data_ok, b_srd;
  logic [22:0] b_saddr;

  int checks = 0, failures = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  jtframe_romrq64_slot #(.AW(22), .DW(16), .LEN(64)) u_dut16 (
    .rst(rst), .clk(clk), .clr(clr), .cs(cs), .addr(addr),
    .dout(dout), .data_ok(data_ok), .sdram_addr(saddr), .sdram_rd(srd),
    .sdram_ack(ack), .sdram_dst(dst), .sdram_dok(dok), .sdram_rdy(rdy), .sdram_din(din));

  jtframe_romrq64_slot #(.AW(22), .DW(32), .LEN(64)) u_dut32 (
    .rst(rst), .clk(clk), .clr(clr), .cs(b_cs), .addr(b_addr),
    .dout(b_dout), .data_ok(b_data_ok), .sdram_addr(b_saddr), .sdram_rd(b_srd),
    .sdram_ack(ack), .sdram_dst(dst), .sdram_dok(dok), .sdram_rdy(rdy), .sdram_din(din));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic cur_rd(input bit sel_b);
    return sel_b ? b_srd : srd;
  endfunction

  function automatic logic [31:0] cur_saddr(input bit sel_b);
    return sel_b ? 32'(b_saddr) : 32'(saddr);
  endfunction

  function automatic logic cur_ok(input bit sel_b);
    return sel_b ? b_data_ok : data_ok;
  endfunction

  // Bank controller model: ack, dst next cycle, then four dok words with rdy on the last
  task automatic serve(input bit sel_b, input logic [31:0] exp_saddr, input logic [15:0] base,
                       input bit chg_en, input logic [21:0] chg_addr);
    for (int i = 0; i < 20 && !cur_rd(sel_b); i++) step();
    chk("rd_req", 32'(cur_rd(sel_b)), 32'd1);
    chk("rd_addr", cur_saddr(sel_b), exp_saddr);
    ack = 1'b1;
    step();
    ack = 1'b0;
    dst = 1'b1;
    chk("rd_drop", 32'(cur_rd(sel_b)), 32'd0);
    step();
    dst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      dok = 1'b1;
      din = base + 16'(k);
      rdy = (k == 3);
      if (chg_en && k == 1) addr = chg_addr;
      step();
      chk("fill_no_ok", 32'(cur_ok(sel_b)), 32'd0);
    end
    dok = 1'b0;
    rdy = 1'b0;
  endtask

  task automatic expect_hit(input bit sel_b, input logic [21:0] a, input logic [31:0] e);
    if (sel_b) b_addr = a; else addr = a;
    exp_q.push_back(e);
    step();
    chk("hit_ok", 32'(cur_ok(sel_b)), 32'd1);
    chk("hit_dout", sel_b ? b_dout : 32'(dout), exp_q.pop_front());
    chk("hit_no_rd", 32'(cur_rd(sel_b)), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  initial begin
    step(); step();
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_ok", 32'(data_ok), 32'd0);
    chk("rst_rd", 32'(srd), 32'd0);
    chk("rst_saddr", 32'(saddr), 32'd0);
    rst = 1'b0;
    cs = 1'b1;
    addr = 22'h10;
    step();
    serve(1'b0, 32'h10, 16'hA0, 1'b0, '0);
    expect_hit(1'b0, 22'h10, 32'hA0);
    expect_hit(1'b0, 22'h11, 32'hA1);
    expect_hit(1'b0, 22'h12, 32'hA2);
    expect_hit(1'b0, 22'h13, 32'hA3);

    // LRU: 0x10 re-hit after 0x20 fill makes 0x20 the victim of 0x30
    addr = 22'h20;
    step();
    chk("miss_ok0", 32'(data_ok), 32'd0);
    serve(1'b0, 32'h20, 16'hB0, 1'b0, '0);
    expect_hit(1'b0, 22'h20, 32'hB0);
    expect_hit(1'b0, 22'h10, 32'hA0);
    addr = 22'h30;
    serve(1'b0, 32'h30, 16'hC0, 1'b0, '0);
    expect_hit(1'b0, 22'h30, 32'hC0);
    expect_hit(1'b0, 22'h12, 32'hA2);
    addr = 22'h20;
    step();
    chk("evict_ok", 32'(data_ok), 32'd0);
    chk("evict_rd", 32'(srd), 32'd1);
    serve(1'b0, 32'h20, 16'hB4, 1'b0, '0);
    expect_hit(1'b0, 22'h23, 32'hB7);

    // Address change mid-fill: burst completes, then a fresh request
    addr = 22'h50;
    serve(1'b0, 32'h50, 16'hD0, 1'b1, 22'h40);
    step();
    chk("chg_no_glitch", 32'(data_ok), 32'd0);
    serve(1'b0, 32'h40, 16'hE0, 1'b0, '0);
    expect_hit(1'b0, 22'h40, 32'hE0);
    expect_hit(1'b0, 22'h52, 32'hD2);
    expect_hit(1'b0, 22'h41, 32'hE1);

    // clr while hitting: clr wins, then the cached address refetches
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("clr_wins", 32'(data_ok), 32'd0);
    step();
    chk("clr_refetch", 32'(srd), 32'd1);
    serve(1'b0, 32'h40, 16'hF0, 1'b0, '0);
    expect_hit(1'b0, 22'h41, 32'hF1);

    // Reset in the middle of a fill
    addr = 22'h60;
    step();
    chk("rst_fill_rd", 32'(srd), 32'd1);
    ack = 1'b1;
    step();
    ack = 1'b0;
    dst = 1'b1;
    step();
    dst = 1'b0;
    dok = 1'b1;
    din = 16'h1111;
    step();
    din = 16'h2222;
    step();
    rst = 1'b1;
    #1;
    chk("mid_rst_dout", 32'(dout), 32'd0);
    chk("mid_rst_ok", 32'(data_ok), 32'd0);
    chk("mid_rst_rd", 32'(srd), 32'd0);
    chk("mid_rst_saddr", 32'(saddr), 32'd0);
    cs = 1'b0;
    step();
    rst = 1'b0;
    din = 16'h3333;
    step();
    din = 16'h4444;
    rdy = 1'b1;
    step();
    dok = 1'b0;
    rdy = 1'b0;
    chk("post_rst_idle", 32'(srd), 32'd0);
    cs = 1'b1;
    addr = 22'h41;
    step();
    chk("post_rst_miss_ok", 32'(data_ok), 32'd0);
    chk("post_rst_miss_rd", 32'(srd), 32'd1);
    serve(1'b0, 32'h40, 16'h70, 1'b0, '0);
    expect_hit(1'b0, 22'h41, 32'h71);
    cs = 1'b0;
    step();

    // 32-bit client: addr 0x9 lives in burst 0x10, upper half of the line
    b_cs = 1'b1;
    b_addr = 22'h9;
    step();
    serve(1'b1, 32'h10, 16'h1230, 1'b0, '0);
    expect_hit(1'b1, 22'h9, 32'h12331232);
    expect_hit(1'b1, 22'h8, 32'h12311230);
    b_cs = 1'b0;
    step();
    chk("b_cs_low_ok", 32'(b_data_ok), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
